// File: rtl/uart_rx_byte.sv
// UART receiver: 8N1 frames on rx become value plus a one-cycle data_valid strobe.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead (even parity checked before the stop bit).
`timescale 1ns/1ps
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] value,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity: the data bits plus the parity bit must hold an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ((^{data, par}) == 1'b0);
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t        state_r;
  logic          rx_meta_r;
  logic          rx_sync_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;
`ifdef UART_RX_PARITY_EN
  logic          parity_r;
`endif

  // Two-flop synchroniser for the asynchronous serial line (idle high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Frame FSM with registered strobes, busy and value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      value       <= 8'h00;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= {CW{1'b0}};
          idx_r <= 3'd0;
          if (!rx_sync_r) begin
            state_r <= START;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (cnt_r == HALF_LAST) begin
            cnt_r <= {CW{1'b0}};
            if (!rx_sync_r) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == FULL_LAST) begin
            cnt_r          <= {CW{1'b0}};
            shift_r[idx_r] <= rx_sync_r;
            if (idx_r == 3'd7) begin
              idx_r   <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_r == FULL_LAST) begin
            cnt_r    <= {CW{1'b0}};
            parity_r <= rx_sync_r;
            state_r  <= STOP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
`endif
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (cnt_r == FULL_LAST) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
            busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (rx_sync_r && even_parity_ok(shift_r, parity_r)) begin
`else
            if (rx_sync_r) begin
`endif
              value      <= shift_r;
              data_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          idx_r   <= 3'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
